lsu_cache_adapter: RTL and testbench

LSU_CACHE_ADAPTER -- requirements
Module: lsu_cache_adapter

---
 rtl/cache_pkg.sv | 32 +++
 rtl/be_merge.sv | 25 ++
 rtl/lsu_cache_adapter.sv | 185 ++++++++++++++++++
 tb/tb_lsu_cache_adapter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the LSU-to-cache adapter and anything that talks to
// the downstream cache: request type encodings, adapter state enumeration and
// the word-address mask.
package cache_pkg;

    // Downstream cache request kinds, as seen on cache_req_type_o.
    typedef enum logic [1:0] {
        CACHE_READ  = 2'b00,
        CACHE_WRITE = 2'b01,
        CACHE_FLUSH = 2'b10
    } cache_type_e;

    // Adapter control states. Every *_ISSUE state is a single-cycle request
    // strobe; every *_WAIT state waits for the cache to report completion.
    typedef enum logic [3:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        MRG_ISSUE,
        MRG_WAIT,
        WR_ISSUE,
        WR_WAIT,
        FL_ISSUE,
        FL_WAIT
    } adapter_state_e;

    // The cache only accepts word-aligned addresses.
    localparam logic [31:0] ADDR_WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [3:0]  BE_FULL        = 4'hF;
    localparam logic [3:0]  BE_NONE        = 4'h0;

endpackage

// File: rtl/be_merge.sv
// Byte-enable merge for partial stores.
// Ports:
//   be_i       : byte enables of the store (bit k covers byte k)
//   new_word_i : store data from the core
//   old_word_i : current memory word returned by the cache
//   merged_o   : per byte, new data where enabled, otherwise old data
module be_merge (
    input  logic [3:0]  be_i,
    input  logic [31:0] new_word_i,
    input  logic [31:0] old_word_i,
    output logic [31:0] merged_o
);

    // NOTE: every signal written in always_comb gets a value on every path
    // (here a default first), otherwise synthesis infers a latch.
    always_comb begin
        merged_o = old_word_i;
        for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
                merged_o[8*k +: 8] = new_word_i[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/lsu_cache_adapter.sv
// Adapter between a core load/store port plus a single-word flush port and a
// request/done style cache. Reads and full-word writes map to one cache
// request; partial writes become a read followed by a merged full-word write;
// a store with no byte enables completes without touching the cache.
// The cache shares this block's reset net; at the top level the cache sees
// the inverted (active-high) polarity of reset_n.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   data_*_i / data_*_o   : core request, grant, response pulse and read data
//   flush_*_i / flush_*_o : flush request, grant and completion pulse
//   cache_req_*_o         : downstream request address/data/type and strobe
//   cache_O_data_i        : downstream read data, valid with cache_req_done_i
//   cache_req_done_i      : downstream completion, honoured only in *_WAIT
module lsu_cache_adapter
    import cache_pkg::*;
#(
    parameter bit FLUSH_PRIORITY = 1'b0  // 0: data wins a tie in IDLE, 1: flush wins
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    input  logic        flush_req_i,
    input  logic [31:0] flush_addr_i,
    output logic        flush_gnt_o,
    output logic        flush_done_o,

    output logic [31:0] cache_req_addr_o,
    output logic [31:0] cache_req_data_o,
    output logic [1:0]  cache_req_type_o,
    output logic        cache_req_do_o,
    input  logic [31:0] cache_O_data_i,
    input  logic        cache_req_done_i
);

    adapter_state_e r_state;
    adapter_state_e w_next_state;

    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_req_data;
    cache_type_e r_req_type;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_flush_done;

    logic        w_data_win;
    logic        w_flush_win;
    logic        w_data_gnt;
    logic        w_flush_gnt;
    logic [31:0] w_merged;

    // Arbitration between simultaneous data and flush requests.
    assign w_data_win  = data_req_i  && (!FLUSH_PRIORITY || !flush_req_i);
    assign w_flush_win = flush_req_i && ( FLUSH_PRIORITY || !data_req_i);

    // Grants are combinational so a new request can be taken in the same
    // cycle that the previous response pulse is shown.
    assign w_data_gnt  = reset_n && (r_state == IDLE) && w_data_win;
    assign w_flush_gnt = reset_n && (r_state == IDLE) && w_flush_win;

    be_merge u_be_merge (
        .be_i       (r_be),
        .new_word_i (r_wdata),
        .old_word_i (cache_O_data_i),
        .merged_o   (w_merged)
    );

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_data_gnt) begin
                    if (!data_we_i) begin
                        w_next_state = RD_ISSUE;
                    end else if (data_be_i == BE_FULL) begin
                        w_next_state = WR_ISSUE;
                    end else if (data_be_i != BE_NONE) begin
                        w_next_state = MRG_ISSUE;
                    end
                    // An empty store stays in IDLE and answers next cycle.
                end else if (w_flush_gnt) begin
                    w_next_state = FL_ISSUE;
                end
            end
            RD_ISSUE:  w_next_state = RD_WAIT;
            MRG_ISSUE: w_next_state = MRG_WAIT;
            WR_ISSUE:  w_next_state = WR_WAIT;
            FL_ISSUE:  w_next_state = FL_WAIT;
            RD_WAIT:   if (cache_req_done_i) w_next_state = IDLE;
            MRG_WAIT:  if (cache_req_done_i) w_next_state = WR_ISSUE;
            WR_WAIT:   if (cache_req_done_i) w_next_state = IDLE;
            FL_WAIT:   if (cache_req_done_i) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    // Request registers only change on a grant or at the end of the merge
    // read, so address/data/type stay stable for the whole cache transaction.
    // NOTE: no memories here; every flop is reset because the outputs must
    // read as zero while reset_n is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_req_data   <= '0;
            r_req_type   <= CACHE_READ;
            r_rdata      <= '0;
            r_rvalid     <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_rvalid     <= 1'b0;
            r_flush_done <= 1'b0;

            if (w_data_gnt) begin
                r_addr     <= data_addr_i & ADDR_WORD_MASK;
                r_we       <= data_we_i;
                r_be       <= data_be_i;
                r_wdata    <= data_wdata_i;
                r_req_data <= data_wdata_i;
                // Partial stores start with a read of the old word.
                r_req_type <= (data_we_i && (data_be_i == BE_FULL)) ? CACHE_WRITE : CACHE_READ;
                if (data_we_i && (data_be_i == BE_NONE)) begin
                    r_rvalid <= 1'b1;
                end
            end else if (w_flush_gnt) begin
                r_addr     <= flush_addr_i & ADDR_WORD_MASK;
                r_req_data <= '0;
                r_req_type <= CACHE_FLUSH;
            end

            if (cache_req_done_i) begin
                case (r_state)
                    RD_WAIT: begin
                        if (!r_we) begin
                            r_rdata <= cache_O_data_i;
                        end
                        r_rvalid <= 1'b1;
                    end
                    MRG_WAIT: begin
                        r_req_data <= w_merged;
                        r_req_type <= CACHE_WRITE;
                    end
                    WR_WAIT: r_rvalid     <= 1'b1;
                    FL_WAIT: r_flush_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign data_gnt_o       = w_data_gnt;
    assign flush_gnt_o      = w_flush_gnt;
    assign data_rvalid_o    = r_rvalid;
    assign data_rdata_o     = r_rdata;
    assign flush_done_o     = r_flush_done;
    assign cache_req_addr_o = r_addr;
    assign cache_req_data_o = r_req_data;
    assign cache_req_type_o = r_req_type;
    assign cache_req_do_o   = (r_state == RD_ISSUE)  || (r_state == MRG_ISSUE) ||
                              (r_state == WR_ISSUE)  || (r_state == FL_ISSUE);

endmodule

// File: tb/tb_lsu_cache_adapter.sv
// Directed self-checking bench for lsu_cache_adapter (FLUSH_PRIORITY = 0).
// Inputs change just after the rising edge or on the falling edge; outputs
// are sampled on the falling edge.
module tb_lsu_cache_adapter;
    import cache_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        flush_req_i;
    logic [31:0] flush_addr_i;
    logic        flush_gnt_o;
    logic        flush_done_o;
    logic [31:0] cache_req_addr_o;
    logic [31:0] cache_req_data_o;
    logic [1:0]  cache_req_type_o;
    logic        cache_req_do_o;
    logic [31:0] cache_O_data_i;
    logic        cache_req_done_i;

    int n_checks = 0;
    int n_errors = 0;

    lsu_cache_adapter #(.FLUSH_PRIORITY(1'b0)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .data_req_i       (data_req_i),
        .data_addr_i      (data_addr_i),
        .data_we_i        (data_we_i),
        .data_be_i        (data_be_i),
        .data_wdata_i     (data_wdata_i),
        .data_gnt_o       (data_gnt_o),
        .data_rvalid_o    (data_rvalid_o),
        .data_rdata_o     (data_rdata_o),
        .flush_req_i      (flush_req_i),
        .flush_addr_i     (flush_addr_i),
        .flush_gnt_o      (flush_gnt_o),
        .flush_done_o     (flush_done_o),
        .cache_req_addr_o (cache_req_addr_o),
        .cache_req_data_o (cache_req_data_o),
        .cache_req_type_o (cache_req_type_o),
        .cache_req_do_o   (cache_req_do_o),
        .cache_O_data_i   (cache_O_data_i),
        .cache_req_done_i (cache_req_done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Present a data request in IDLE, confirm the grant, drop the request.
    // Ends on the falling edge of the cycle after the grant edge.
    task automatic request_data(input string tag, input logic we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata);
        tick();
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        settle();
        check({tag, "_gnt"}, 32'(data_gnt_o), 32'd1);
        tick();
        data_req_i = 1'b0;
        settle();
    endtask

    // Wait (bounded) for a request strobe, check its fields, and check that
    // the strobe lasts a single cycle. Ends on a falling edge in the WAIT state.
    task automatic wait_issue(input string tag, input cache_type_e typ, input logic [31:0] addr,
                              input logic [31:0] data, input bit chk_data);
        int n = 0;
        while (!cache_req_do_o && n < 10) begin
            tick();
            settle();
            n++;
        end
        check({tag, "_do"},   32'(cache_req_do_o), 32'd1);
        check({tag, "_type"}, 32'(cache_req_type_o), 32'(typ));
        check({tag, "_addr"}, cache_req_addr_o, addr);
        if (chk_data) begin
            check({tag, "_data"}, cache_req_data_o, data);
        end
        tick();
        settle();
        check({tag, "_do_pulse"}, 32'(cache_req_do_o), 32'd0);
    endtask

    // Answer the outstanding cache request. Ends on the falling edge of the
    // cycle after the done cycle.
    task automatic respond(input logic [31:0] rdata);
        cache_req_done_i = 1'b1;
        cache_O_data_i   = rdata;
        tick();
        cache_req_done_i = 1'b0;
        cache_O_data_i   = 32'h5A5A_5A5A;
        settle();
    endtask

    initial begin
        reset_n          = 1'b0;
        data_req_i       = 1'b1;
        data_addr_i      = 32'h0;
        data_we_i        = 1'b0;
        data_be_i        = 4'h0;
        data_wdata_i     = 32'h0;
        flush_req_i      = 1'b0;
        flush_addr_i     = 32'h0;
        cache_O_data_i   = 32'h0;
        cache_req_done_i = 1'b0;

        // Reset state: grant suppressed even with a request pending.
        repeat (2) @(posedge clk);
        settle();
        check("rst_gnt",    32'(data_gnt_o), 32'd0);
        check("rst_do",     32'(cache_req_do_o), 32'd0);
        check("rst_rvalid", 32'(data_rvalid_o), 32'd0);
        check("rst_type",   32'(cache_req_type_o), 32'(CACHE_READ));
        check("rst_addr",   cache_req_addr_o, 32'h0);
        check("rst_rdata",  data_rdata_o, 32'h0);
        data_req_i = 1'b0;
        reset_n    = 1'b1;

        // Read 0x104 returning 0xDEAD_BEEF, with one extra wait cycle.
        request_data("rd", 1'b0, 4'hF, 32'h0000_0104, 32'h0);
        wait_issue("rd", CACHE_READ, 32'h0000_0104, 32'h0, 1'b0);
        check("rd_wait_rvalid", 32'(data_rvalid_o), 32'd0);
        tick();
        settle();
        check("rd_wait_do", 32'(cache_req_do_o), 32'd0);
        respond(32'hDEAD_BEEF);
        check("rd_rvalid", 32'(data_rvalid_o), 32'd1);
        check("rd_rdata",  data_rdata_o, 32'hDEAD_BEEF);
        tick();
        settle();
        check("rd_rvalid_pulse", 32'(data_rvalid_o), 32'd0);

        // Full-word write.
        request_data("wr", 1'b1, 4'hF, 32'h0000_0200, 32'h1234_5678);
        wait_issue("wr", CACHE_WRITE, 32'h0000_0200, 32'h1234_5678, 1'b1);
        respond(32'h0);
        check("wr_rvalid", 32'(data_rvalid_o), 32'd1);
        check("wr_rdata",  data_rdata_o, 32'hDEAD_BEEF);

        // Partial write: read old word then write merged word.
        request_data("mrg", 1'b1, 4'b0101, 32'h0000_0300, 32'hAABB_CCDD);
        wait_issue("mrg_rd", CACHE_READ, 32'h0000_0300, 32'h0, 1'b0);
        respond(32'h1122_3344);
        check("mrg_mid_rvalid", 32'(data_rvalid_o), 32'd0);
        wait_issue("mrg_wr", CACHE_WRITE, 32'h0000_0300, 32'h11BB_33DD, 1'b1);
        respond(32'h0);
        check("mrg_rvalid", 32'(data_rvalid_o), 32'd1);

        // Data and flush together: data first, flush granted in rvalid cycle.
        tick();
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h0000_0404;
        flush_req_i  = 1'b1;
        flush_addr_i = 32'h0000_033B;
        settle();
        check("arb_data_gnt",  32'(data_gnt_o), 32'd1);
        check("arb_flush_gnt", 32'(flush_gnt_o), 32'd0);
        tick();
        data_req_i = 1'b0;
        settle();
        wait_issue("arb_rd", CACHE_READ, 32'h0000_0404, 32'h0, 1'b0);
        check("arb_flush_held", 32'(flush_gnt_o), 32'd0);
        respond(32'hCAFE_F00D);
        check("arb_rvalid",     32'(data_rvalid_o), 32'd1);
        check("arb_rdata",      data_rdata_o, 32'hCAFE_F00D);
        check("arb_flush_b2b",  32'(flush_gnt_o), 32'd1);
        tick();
        flush_req_i = 1'b0;
        settle();
        wait_issue("fl", CACHE_FLUSH, 32'h0000_0338, 32'h0, 1'b0);
        respond(32'h0);
        check("fl_done",   32'(flush_done_o), 32'd1);
        check("fl_rvalid", 32'(data_rvalid_o), 32'd0);
        tick();
        settle();
        check("fl_done_pulse", 32'(flush_done_o), 32'd0);

        // Store with no byte enables: answered next cycle, no cache access.
        request_data("be0", 1'b1, 4'h0, 32'h0000_0500, 32'hFFFF_FFFF);
        check("be0_rvalid", 32'(data_rvalid_o), 32'd1);
        check("be0_do",     32'(cache_req_do_o), 32'd0);
        tick();
        settle();
        check("be0_rvalid_pulse", 32'(data_rvalid_o), 32'd0);
        check("be0_do_after",     32'(cache_req_do_o), 32'd0);

        // Stray done in IDLE is ignored.
        cache_req_done_i = 1'b1;
        cache_O_data_i   = 32'h7777_7777;
        tick();
        cache_req_done_i = 1'b0;
        settle();
        check("stray_rvalid", 32'(data_rvalid_o), 32'd0);
        check("stray_fdone",  32'(flush_done_o), 32'd0);
        check("stray_rdata",  data_rdata_o, 32'hCAFE_F00D);

        // Reset during RD_WAIT aborts silently; next read completes.
        request_data("abort", 1'b0, 4'hF, 32'h0000_0600, 32'h0);
        wait_issue("abort", CACHE_READ, 32'h0000_0600, 32'h0, 1'b0);
        reset_n    = 1'b0;
        data_req_i = 1'b1;
        #1;
        check("abort_gnt",   32'(data_gnt_o), 32'd0);
        check("abort_do",    32'(cache_req_do_o), 32'd0);
        check("abort_addr",  cache_req_addr_o, 32'h0);
        check("abort_rdata", data_rdata_o, 32'h0);
        cache_req_done_i = 1'b1;
        tick();
        cache_req_done_i = 1'b0;
        settle();
        check("abort_rvalid", 32'(data_rvalid_o), 32'd0);
        check("abort_type",   32'(cache_req_type_o), 32'(CACHE_READ));
        data_req_i = 1'b0;
        reset_n    = 1'b1;
        request_data("post", 1'b0, 4'hF, 32'h0000_0700, 32'h0);
        wait_issue("post", CACHE_READ, 32'h0000_0700, 32'h0, 1'b0);
        respond(32'h0BAD_F00D);
        check("post_rvalid", 32'(data_rvalid_o), 32'd1);
        check("post_rdata",  data_rdata_o, 32'h0BAD_F00D);

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
